dmem_access_ctrl: RTL

- Sequences all data-memory traffic between two requesters: the UART program/data loader and the CPU load/store path.
- Sits in front of the single-port, word-wide `data_mem` RAM inside `cpu_uart_top`.
- Arbitrates between the two requesters.
- Implements SB/SH as read-modify-write, because the RAM has no byte enables.
- Sign- or zero-extends LB/LH/LBU/LHU results.

---
 rtl/dmem_access_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory sequencer: arbitrates loader writes and CPU loads/stores onto a single-port
// word RAM, doing SB/SH as read-modify-write. Optional `DMEM_MISALIGN_TRAP_EN` enables misalignment faults.
module dmem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [ADDR_W+1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_fault,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LWR, S_SWR, S_RD, S_MERGE, S_LDATA, S_RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;

  // Decoded request width; unknown funct3 codes behave as a word access.
  logic [1:0] size_in;
  logic       uns_in;
  logic       misalign_in;

  always_comb begin
    size_in = SZ_W;
    uns_in  = 1'b0;
    case (cpu_funct3)
      3'b000:  size_in = SZ_B;
      3'b001:  size_in = SZ_H;
      3'b100: begin size_in = SZ_B; uns_in = 1'b1; end
      3'b101: begin size_in = SZ_H; uns_in = 1'b1; end
      default: size_in = SZ_W;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_in = ((size_in == SZ_H) && cpu_addr[0]) ||
                       ((size_in == SZ_W) && (cpu_addr[1:0] != 2'b00));
`else
  assign misalign_in = 1'b0;
`endif

  // Store merge: each byte lane takes new data when the access covers it.
  logic [31:0] merge_word;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;
      always_comb begin
        hit = 1'b0;
        src = wdata_q[8*gi +: 8];
        case (size_q)
          SZ_B: begin hit = (addr_q[1:0] == LANE); src = wdata_q[7:0]; end
          SZ_H: begin hit = (addr_q[1] == LANE[1]); src = wdata_q[8*(gi%2) +: 8]; end
          default: begin hit = 1'b1; src = wdata_q[8*gi +: 8]; end
        endcase
      end
      assign merge_word[8*gi +: 8] = hit ? src : mem_rdata[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    load_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_data_d = ld_data_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    ld_ready  = 1'b0;
    cpu_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          ld_addr_d = ld_addr;
          ld_data_d = ld_data;
          state_d   = S_LWR;
        end else if (cpu_req) begin
          we_d    = cpu_we;
          size_d  = size_in;
          uns_d   = uns_in;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          fault_d = misalign_in;
          if (misalign_in)                   state_d = S_RESP;
          else if (cpu_we && size_in == SZ_W) state_d = S_SWR;
          else                               state_d = S_RD;
        end
      end
      S_LWR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr_q;
        mem_wdata = ld_data_q;
        ld_ready  = 1'b1;
        state_d   = S_IDLE;
      end
      S_SWR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[ADDR_W+1:2];
        mem_wdata = wdata_q;
        state_d   = S_RESP;
      end
      S_RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q[ADDR_W+1:2];
        state_d  = we_q ? S_MERGE : S_LDATA;
      end
      S_MERGE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[ADDR_W+1:2];
        mem_wdata = merge_word;
        state_d   = S_RESP;
      end
      S_LDATA: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RESP: begin
        cpu_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset arriving mid-transaction must not let a write or handshake escape.
    if (rst) begin
      ld_ready  = 1'b0;
      cpu_ready = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ld_addr_q <= '0;
      ld_data_q <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_W;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_data_q <= ld_data_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
    end
  end

  assign cpu_rdata = rdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign cpu_fault = cpu_ready & fault_q;
`else
  assign cpu_fault = 1'b0;
`endif

endmodule
